cnsa_pipe_adder: RTL and testbench

- Parametrised, pipelined conditional-sum adder/subtractor. Operands are split into SEG_W-bit segments; each segment precomputes sum and carry for carry-in 0 and 1, then a segment-level carry-select chain picks the final result.
- Adds a subtract mode, a signed-overflow flag, and a valid/ready stream interface with full backpressure.
- Drop-in arithmetic stage for the datapath; fixed 3-stage pipeline.

---
 rtl/cnsa_pkg.sv | 15 +
 rtl/cnsa_segment.sv | 22 ++
 rtl/cnsa_pipe_adder.sv | 184 ++++++++++++++++++
 tb/tb_cnsa_pipe_adder.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnsa_pkg.sv
// Shared constants and helpers for the pipelined conditional-sum adder/subtractor.
package cnsa_pkg;

    localparam int LATENCY = 3;

    function automatic int seg_count(input int n, input int seg_w);
        return n / seg_w;
    endfunction

    // Subtraction is A + ~B + 1, so the incoming carry is forced high in sub mode.
    function automatic logic eff_cin(input logic sub, input logic cin);
        return sub | cin;
    endfunction

endpackage

// File: rtl/cnsa_segment.sv
// One conditional-sum segment: sum and carry precomputed for both possible carry-ins.
module cnsa_segment #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    output logic [SEG_W-1:0] s0,
    output logic [SEG_W-1:0] s1,
    output logic             c0,
    output logic             c1,
    output logic             c_msb0,
    output logic             c_msb1
);

    assign {c0, s0} = {1'b0, a} + {1'b0, b};
    assign {c1, s1} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, 1'b1};

    // The carry into the top bit is recovered from that bit's sum and operands.
    assign c_msb0 = s0[SEG_W-1] ^ a[SEG_W-1] ^ b[SEG_W-1];
    assign c_msb1 = s1[SEG_W-1] ^ a[SEG_W-1] ^ b[SEG_W-1];

endmodule

// File: rtl/cnsa_pipe_adder.sv
// Three-stage conditional-sum adder/subtractor with valid/ready handshake and full backpressure.
module cnsa_pipe_adder
    import cnsa_pkg::*;
#(
    parameter int N     = 32,
    parameter int SEG_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic         Cin,
    input  logic [N-1:0] operA,
    input  logic [N-1:0] operB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] resultOUT,
    output logic         Cout,
    output logic         ovf
);

    localparam int NSEG = seg_count(N, SEG_W);

    generate
        if ((SEG_W < 1) || (SEG_W > N) || ((N % SEG_W) != 0)) begin : g_param_check
            $error("cnsa_pipe_adder: N must be a positive multiple of SEG_W");
        end
    endgenerate

    typedef struct packed {
        logic [SEG_W-1:0] s0;
        logic [SEG_W-1:0] s1;
        logic             c0;
        logic             c1;
    } seg_cond_t;

    // Stage 1: operands with B and carry-in already adjusted for sub mode
    logic         s1_valid_reg;
    logic [N-1:0] s1_a_reg;
    logic [N-1:0] s1_b_reg;
    logic         s1_cin_reg;

    // Stage 2: per-segment conditional results
    logic         s2_valid_reg;
    seg_cond_t    s2_seg_reg [NSEG];
    logic         s2_cin_reg;
    logic         s2_cmsb0_reg;
    logic         s2_cmsb1_reg;

    // Stage 3: selected result
    logic         out_valid_reg;
    logic [N-1:0] result_reg;
    logic         cout_reg;
    logic         ovf_reg;

    logic         s3_adv;
    logic         s2_adv;
    logic         s1_accept;
    logic         s2_load;
    logic         s3_load;

    assign s3_adv    = !out_valid_reg || out_ready;
    assign s2_adv    = !s2_valid_reg || s3_adv;
    assign in_ready  = !s1_valid_reg || s2_adv;
    assign s1_accept = in_valid && in_ready;
    assign s2_load   = s2_adv && s1_valid_reg;
    assign s3_load   = s3_adv && s2_valid_reg;

    // Valid bits: an empty stage always takes whatever the previous stage holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
            end
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_accept) begin
            s1_a_reg   <= operA;
            s1_b_reg   <= sub ? ~operB : operB;
            s1_cin_reg <= eff_cin(sub, Cin);
        end
    end

    logic [N-1:0]    s0_all;
    logic [N-1:0]    s1_all;
    logic [NSEG-1:0] c0_all;
    logic [NSEG-1:0] c1_all;
    logic            cmsb0_top;
    logic            cmsb1_top;

    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
            if (gi == NSEG - 1) begin : g_msb
                cnsa_segment #(.SEG_W(SEG_W)) u_seg (
                    .a      (s1_a_reg[gi*SEG_W +: SEG_W]),
                    .b      (s1_b_reg[gi*SEG_W +: SEG_W]),
                    .s0     (s0_all[gi*SEG_W +: SEG_W]),
                    .s1     (s1_all[gi*SEG_W +: SEG_W]),
                    .c0     (c0_all[gi]),
                    .c1     (c1_all[gi]),
                    .c_msb0 (cmsb0_top),
                    .c_msb1 (cmsb1_top)
                );
            end else begin : g_low
                // Carries into a lower segment's top bit play no part in overflow.
                logic unused_cmsb0;
                logic unused_cmsb1;
                cnsa_segment #(.SEG_W(SEG_W)) u_seg (
                    .a      (s1_a_reg[gi*SEG_W +: SEG_W]),
                    .b      (s1_b_reg[gi*SEG_W +: SEG_W]),
                    .s0     (s0_all[gi*SEG_W +: SEG_W]),
                    .s1     (s1_all[gi*SEG_W +: SEG_W]),
                    .c0     (c0_all[gi]),
                    .c1     (c1_all[gi]),
                    .c_msb0 (unused_cmsb0),
                    .c_msb1 (unused_cmsb1)
                );
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (s2_load) begin
            for (int i = 0; i < NSEG; i++) begin
                s2_seg_reg[i].s0 <= s0_all[i*SEG_W +: SEG_W];
                s2_seg_reg[i].s1 <= s1_all[i*SEG_W +: SEG_W];
                s2_seg_reg[i].c0 <= c0_all[i];
                s2_seg_reg[i].c1 <= c1_all[i];
            end
            s2_cin_reg   <= s1_cin_reg;
            s2_cmsb0_reg <= cmsb0_top;
            s2_cmsb1_reg <= cmsb1_top;
        end
    end

    // Segment-level carry-select chain; carry_sel[j] is the carry into segment j.
    logic [NSEG:0] carry_sel;
    logic [N-1:0]  sum_next;
    logic          c_into_msb;
    logic          ovf_next;

    assign carry_sel[0] = s2_cin_reg;

    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_sel
            assign sum_next[gi*SEG_W +: SEG_W] = carry_sel[gi] ? s2_seg_reg[gi].s1 : s2_seg_reg[gi].s0;
            assign carry_sel[gi+1]             = carry_sel[gi] ? s2_seg_reg[gi].c1 : s2_seg_reg[gi].c0;
        end
    endgenerate

    assign c_into_msb = carry_sel[NSEG-1] ? s2_cmsb1_reg : s2_cmsb0_reg;
    assign ovf_next   = c_into_msb ^ carry_sel[NSEG];

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (s3_adv) begin
            out_valid_reg <= s2_valid_reg;
            if (s3_load) begin
                result_reg <= sum_next;
                cout_reg   <= carry_sel[NSEG];
                ovf_reg    <= ovf_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign resultOUT = result_reg;
    assign Cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_cnsa_pipe_adder.sv
// Scoreboard bench for cnsa_pipe_adder: directed vector table, stall/reset sequences, random traffic.
module tb_cnsa_pipe_adder;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         sub;
    logic         Cin;
    logic [N-1:0] operA;
    logic [N-1:0] operB;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] resultOUT;
    logic         Cout;
    logic         ovf;

    always #5 clk = ~clk;

    cnsa_pipe_adder #(.N(N), .SEG_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .Cin       (Cin),
        .operA     (operA),
        .operB     (operB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resultOUT (resultOUT),
        .Cout      (Cout),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [N-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         s;
        logic         c;
        exp_t         e;
    } vec_t;

    int      checks   = 0;
    int      failures = 0;
    int      acc_cnt  = 0;
    int      out_cnt  = 0;
    bit      verbose  = 1'b1;
    bit      rand_or  = 1'b0;
    exp_t    sb[$];
    exp_t    cur_exp;
    exp_t    mon_e;
    bit      hold_prev = 1'b0;
    logic [N+1:0] hold_snap;

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic s, input logic c);
        exp_t         r;
        logic [N-1:0] bb;
        logic         ci;
        logic [N:0]   t;
        bb     = s ? ~b : b;
        ci     = s | c;
        t      = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, ci};
        r.res  = t[N-1:0];
        r.cout = t[N];
        r.ovf  = (a[N-1] == bb[N-1]) && (t[N-1] != a[N-1]);
        return r;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                                input logic c, input logic [N-1:0] res, input logic co, input logic ov);
        vec_t v;
        v.a = a; v.b = b; v.s = s; v.c = c;
        v.e.res = res; v.e.cout = co; v.e.ovf = ov;
        return v;
    endfunction

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return N'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: handshakes are evaluated mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", 64'({resultOUT, Cout, ovf}), 64'(hold_snap));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got res=0x%08h expected no output", resultOUT);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", 64'(resultOUT), 64'(mon_e.res));
                    check("cout", 64'(Cout), 64'(mon_e.cout));
                    check("ovf", 64'(ovf), 64'(mon_e.ovf));
                    if (verbose)
                        $display("out #%0d res=0x%08h cout=%0b ovf=%0b", out_cnt, resultOUT, Cout, ovf);
                end
                out_cnt++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(cur_exp);
                acc_cnt++;
            end
            hold_prev = out_valid && !out_ready;
            hold_snap = {resultOUT, Cout, ovf};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Presents one operation and returns 1ns after the edge that accepts it; in_valid stays high.
    task automatic send(input vec_t v, output int stalls);
        operA = v.a; operB = v.b; sub = v.s; Cin = v.c;
        cur_exp  = v.e;
        in_valid = 1'b1;
        stalls   = 0;
        @(negedge clk);
        while (!in_ready && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 expected accept within 200 cycles");
            in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_vec(output vec_t v);
        v.a = pick();
        v.b = pick();
        v.s = 1'($urandom_range(0, 1));
        v.c = 1'($urandom_range(0, 1));
        v.e = model(v.a, v.b, v.s, v.c);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic latency_probe(input vec_t v, input string name);
        int st;
        send(v, st);
        in_valid = 1'b0;
        check({name, "_k"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check({name, "_k1"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check({name, "_k2"}, 64'(out_valid), 64'(1));
    endtask

    vec_t tbl[10];
    vec_t v;
    int   st;
    int   total_st;
    int   acc0;
    int   out0;

    initial begin
        tbl[0] = mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        tbl[1] = mk(32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        tbl[2] = mk(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
        tbl[3] = mk(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        tbl[4] = mk(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        tbl[5] = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        tbl[6] = mk(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        tbl[7] = mk(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        tbl[8] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        tbl[9] = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

        reset = 1'b1; in_valid = 1'b0; sub = 1'b0; Cin = 1'b0;
        operA = '0; operB = '0; out_ready = 1'b1; cur_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outputs", 64'({resultOUT, Cout, ovf}), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed table: first entry also pins the two-edge output latency
        latency_probe(tbl[0], "lat_first");
        wait_drain("tbl0_drain");
        total_st = 0;
        for (int i = 1; i < 10; i++) begin
            send(tbl[i], st);
            total_st += st;
        end
        in_valid = 1'b0;
        check("tbl_stalls", 64'(total_st), 64'(0));
        wait_drain("tbl_drain");

        // Backpressure: five ops against a stalled sink for six cycles
        acc0 = acc_cnt; out0 = out_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    rnd_vec(v);
                    send(v, st);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                check("bp_accepts", 64'(acc_cnt - acc0), 64'(3));
                check("bp_in_ready", 64'(in_ready), 64'(0));
                check("bp_out_valid", 64'(out_valid), 64'(1));
                out_ready = 1'b1;
            end
        join
        wait_drain("bp_drain");
        check("bp_out_count", 64'(out_cnt - out0), 64'(5));

        total_st = 0;
        for (int i = 0; i < 8; i++) begin
            rnd_vec(v);
            send(v, st);
            total_st += st;
        end
        in_valid = 1'b0;
        check("thru_stalls", 64'(total_st), 64'(0));
        wait_drain("thru_drain");

        // Reset with three ops in flight: none may emerge afterwards
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rnd_vec(v);
            send(v, st);
        end
        in_valid = 1'b0;
        check("mid_full", 64'(out_valid), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        reset = 1'b0;
        out_ready = 1'b1;
        out0 = out_cnt;
        repeat (6) @(posedge clk);
        #1;
        check("mid_no_emit", 64'(out_cnt - out0), 64'(0));
        latency_probe(tbl[5], "lat_after_rst");
        wait_drain("rst_drain");

        // Random traffic with random sink stalls
        verbose = 1'b0;
        rand_or = 1'b1;
        acc0 = acc_cnt; out0 = out_cnt;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            rnd_vec(v);
            send(v, st);
        end
        in_valid = 1'b0;
        rand_or = 1'b0;
        out_ready = 1'b1;
        wait_drain("rand_drain");
        check("rand_in_count", 64'(acc_cnt - acc0), 64'(10000));
        check("rand_in_eq_out", 64'(out_cnt - out0), 64'(acc_cnt - acc0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
